// File: rtl/crank_gen_pkg.sv
// Shared types and constants for the 60-2 crank trigger-wheel generator.
package crank_gen_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam int CRANK_TEETH_TOTAL   = 60;
    localparam int CRANK_TEETH_MISSING = 2;
    localparam int CRANK_MIN_PERIOD    = 4;

endpackage

// File: rtl/crank_wheel_gen_if.sv
// Control and waveform bundle between the wheel generator and its user.
interface crank_wheel_gen_if #(
    parameter int PERIOD_WIDTH = 24,
    parameter int TOOTH_WIDTH  = 8
);

    logic                    ena;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    period_load;
    logic                    cap_out;
    logic [TOOTH_WIDTH-1:0]  tooth_num;
    logic                    tooth_stb;
    logic                    gap_stb;
    logic                    busy;

    modport master (
        output ena,
        output period,
        output period_load,
        input  cap_out,
        input  tooth_num,
        input  tooth_stb,
        input  gap_stb,
        input  busy
    );

    modport slave (
        input  ena,
        input  period,
        input  period_load,
        output cap_out,
        output tooth_num,
        output tooth_stb,
        output gap_stb,
        output busy
    );

endinterface

// File: rtl/crank_tooth_timer.sv
// Per-tooth phase counter and active period; flags the tooth boundary and
// the high phase of the cycle that follows the next clock edge.
module crank_tooth_timer #(
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    run,
    input  logic [PERIOD_WIDTH-1:0] sh_per,
    output logic                    bnd,
    output logic                    hi_nxt
);

    localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);

    logic [PERIOD_WIDTH-1:0] pcnt;
    logic [PERIOD_WIDTH-1:0] act_per;
    logic [PERIOD_WIDTH-1:0] pcnt_n;
    logic [PERIOD_WIDTH-1:0] act_n;

    assign bnd = run && (pcnt == act_per - ONE);

    // Period changes only take effect at a tooth start.
    always_comb begin
        pcnt_n = '0;
        act_n  = act_per;
        if (start || bnd) begin
            act_n = sh_per;
        end else if (run) begin
            pcnt_n = pcnt + ONE;
        end
        hi_nxt = pcnt_n < (act_n >> 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt    <= '0;
            act_per <= '0;
        end else begin
            pcnt    <= pcnt_n;
            act_per <= act_n;
        end
    end

endmodule

// File: rtl/crank_wheel_gen.sv
// 60-2 trigger-wheel source: run/idle FSM, shadow period, tooth index and
// registered wheel waveform with tooth and gap strobes.
module crank_wheel_gen
    import crank_gen_pkg::*;
#(
    parameter int PERIOD_WIDTH  = 24,
    parameter int TOOTH_WIDTH   = 8,
    parameter int TEETH_TOTAL   = CRANK_TEETH_TOTAL,
    parameter int TEETH_MISSING = CRANK_TEETH_MISSING
) (
    input logic              clk,
    input logic              rst,
    crank_wheel_gen_if.slave bus
);

    localparam logic [PERIOD_WIDTH-1:0] MIN_PER =
        PERIOD_WIDTH'(CRANK_MIN_PERIOD);
    localparam logic [TOOTH_WIDTH-1:0] T_ONE  = TOOTH_WIDTH'(1);
    localparam logic [TOOTH_WIDTH-1:0] T_LAST = TOOTH_WIDTH'(TEETH_TOTAL - 1);
    localparam logic [TOOTH_WIDTH-1:0] T_MISS =
        TOOTH_WIDTH'(TEETH_TOTAL - TEETH_MISSING);

    state_t                  state;
    logic [PERIOD_WIDTH-1:0] sh_per;
    logic [PERIOD_WIDTH-1:0] per_in;
    logic [TOOTH_WIDTH-1:0]  tooth_num;
    logic [TOOTH_WIDTH-1:0]  tooth_n;
    logic                    cap_out;
    logic                    tooth_stb;
    logic                    gap_stb;
    logic                    busy;

    logic start;
    logic run;
    logic stop;
    logic adv;
    logic last;
    logic live_n;
    logic bnd;
    logic hi_nxt;

    // Short nonzero periods are raised to keep a distinct high and low phase.
    always_comb begin
        per_in = bus.period;
        if (bus.period != '0 && bus.period < MIN_PER) begin
            per_in = MIN_PER;
        end
    end

    assign run    = (state == RUN);
    assign start  = (state == IDLE) && bus.ena && (sh_per != '0);
    assign stop   = bnd && (!bus.ena || sh_per == '0);
    assign adv    = bnd && !stop;
    assign last   = (tooth_num == T_LAST);
    assign live_n = start || (run && !stop);

    always_comb begin
        tooth_n = tooth_num;
        if (start || stop) begin
            tooth_n = '0;
        end else if (adv) begin
            tooth_n = last ? '0 : tooth_num + T_ONE;
        end
    end

    crank_tooth_timer #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .run    (run),
        .sh_per (sh_per),
        .bnd    (bnd),
        .hi_nxt (hi_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sh_per    <= '0;
            tooth_num <= '0;
            cap_out   <= 1'b0;
            tooth_stb <= 1'b0;
            gap_stb   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (bus.period_load) begin
                sh_per <= per_in;
            end
            unique case (state)
                IDLE: if (start) state <= RUN;
                RUN:  if (stop) state <= IDLE;
            endcase
            tooth_num <= tooth_n;
            tooth_stb <= start || adv;
            gap_stb   <= start || (adv && last);
            busy      <= live_n;
            // Missing positions stay low for their whole period.
            cap_out   <= live_n && hi_nxt && (tooth_n < T_MISS);
        end
    end

    assign bus.cap_out   = cap_out;
    assign bus.tooth_num = tooth_num;
    assign bus.tooth_stb = tooth_stb;
    assign bus.gap_stb   = gap_stb;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Scoreboard bench: stimulus queues expected tooth shapes, a monitor
// measures each tooth and compares it on completion.
module tb_crank_wheel_gen;
    import crank_gen_pkg::*;

    localparam int PW   = 24;
    localparam int TW   = 8;
    localparam int NTOT = 60;
    localparam int NMIS = 2;

    typedef struct packed {
        logic [7:0]  num;
        logic        gap;
        logic [11:0] lead;
        logic [11:0] hi;
        logic [11:0] len;
    } trec_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    n_pass = 0;
    int    n_tot = 0;
    int    cyc = 0;
    trec_t exp_q[$];

    crank_wheel_gen_if #(.PERIOD_WIDTH(PW), .TOOTH_WIDTH(TW)) bus ();

    crank_wheel_gen #(
        .PERIOD_WIDTH  (PW),
        .TOOTH_WIDTH   (TW),
        .TEETH_TOTAL   (NTOT),
        .TEETH_MISSING (NMIS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0d want %0d", nm, act, exp);
        else n_pass++;
    endtask

    task automatic push_teeth(input int first, input int last, input int per);
        trec_t r;
        for (int t = first; t <= last; t++) begin
            r.num  = 8'(t);
            r.gap  = (t == 0);
            r.len  = 12'(per);
            r.hi   = (t < NTOT - NMIS) ? 12'(per / 2) : 12'd0;
            r.lead = r.hi;
            exp_q.push_back(r);
        end
    endtask

    // ---------------- monitor ----------------
    trec_t cur;
    bit    on = 0;
    bit    still = 0;

    task automatic close_rec();
        trec_t e;
        n_tot++;
        if (exp_q.size() == 0) begin
            $display("FAIL tooth_extra: got tooth %0d want none", cur.num);
        end else begin
            e = exp_q.pop_front();
            if (cur !== e)
                $display({"FAIL tooth_%0d: got n=%0d g=%0d lead=%0d hi=%0d ",
                          "len=%0d want n=%0d g=%0d lead=%0d hi=%0d len=%0d"},
                         e.num, cur.num, cur.gap, cur.lead, cur.hi, cur.len,
                         e.num, e.gap, e.lead, e.hi, e.len);
            else n_pass++;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            on = 0;
        end else if (bus.tooth_stb) begin
            if (on) close_rec();
            cur.num  = bus.tooth_num;
            cur.gap  = bus.gap_stb;
            cur.len  = 12'd1;
            cur.hi   = {11'd0, bus.cap_out};
            cur.lead = cur.hi;
            still    = bus.cap_out;
            on       = 1;
        end else if (on && bus.busy) begin
            cur.len = cur.len + 12'd1;
            if (bus.cap_out) begin
                cur.hi = cur.hi + 12'd1;
                if (still) cur.lead = cur.lead + 12'd1;
            end else begin
                still = 0;
            end
        end else if (on) begin
            close_rec();
            on = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input int p);
        @(posedge clk);
        #1;
        bus.period      = PW'(p);
        bus.period_load = 1'b1;
        @(posedge clk);
        #1;
        bus.period_load = 1'b0;
    endtask

    task automatic wait_stb(input bit gap, input int num, input string nm);
        bit hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            hit = bus.tooth_stb &&
                  (gap ? bus.gap_stb : (int'(bus.tooth_num) == num));
        end
        if (!hit) begin
            n_tot++;
            $display("FAIL %s: got timeout want strobe", nm);
        end
    endtask

    task automatic wait_idle(input string nm);
        bit hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            hit = !bus.busy;
        end
        if (!hit) begin
            n_tot++;
            $display("FAIL %s: got timeout want idle", nm);
        end
    endtask

    task automatic stop_now();
        @(posedge clk);
        #1;
        bus.ena = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int t1, t2, hb, hc;
        bus.ena         = 1'b0;
        bus.period      = '0;
        bus.period_load = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cap", 32'(bus.cap_out), 0);
        chk("rst_tooth", 32'(bus.tooth_num), 0);
        chk("rst_tstb", 32'(bus.tooth_stb), 0);
        chk("rst_gstb", 32'(bus.gap_stb), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst = 1'b1;

        // two revolutions plus tooth 0 at P=8
        push_teeth(0, NTOT - 1, 8);
        push_teeth(0, 0, 8);
        load(8);
        bus.ena = 1'b1;
        wait_stb(1, 0, "gap1");
        t1 = cyc;
        wait_stb(1, 0, "gap2");
        t2 = cyc;
        chk("gap_interval", 32'(t2 - t1), 480);
        stop_now();
        wait_idle("idle_basic");
        chk("basic_tooth0", 32'(bus.tooth_num), 0);
        chk("basic_cap0", 32'(bus.cap_out), 0);
        #1 chk("sb_basic", 32'(exp_q.size()), 0);

        // period change mid tooth 5
        push_teeth(0, 5, 8);
        push_teeth(6, 6, 20);
        bus.ena = 1'b1;
        wait_stb(0, 5, "t5");
        repeat (3) @(posedge clk);
        #1;
        bus.period      = PW'(20);
        bus.period_load = 1'b1;
        @(posedge clk);
        #1 bus.period_load = 1'b0;
        wait_stb(0, 6, "t6");
        stop_now();
        wait_idle("idle_mid");
        #1 chk("sb_mid", 32'(exp_q.size()), 0);

        // clamp 2 -> 4
        push_teeth(0, 2, 4);
        load(2);
        bus.ena = 1'b1;
        wait_stb(0, 2, "clamp_t2");
        stop_now();
        wait_idle("idle_clamp");
        #1 chk("sb_clamp", 32'(exp_q.size()), 0);

        // zero period never starts
        load(0);
        bus.ena = 1'b1;
        hb = 0;
        hc = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.busy) hb++;
            if (bus.cap_out) hc++;
        end
        chk("zero_busy", 32'(hb), 0);
        chk("zero_cap", 32'(hc), 0);
        bus.ena = 1'b0;

        // graceful stop in tooth 10 with a coincident load of 12
        push_teeth(0, 10, 8);
        load(8);
        bus.ena = 1'b1;
        wait_stb(0, 10, "stop_t10");
        @(posedge clk);
        #1;
        bus.ena         = 1'b0;
        bus.period      = PW'(12);
        bus.period_load = 1'b1;
        @(posedge clk);
        #1 bus.period_load = 1'b0;
        wait_idle("idle_stop");
        chk("stop_tooth0", 32'(bus.tooth_num), 0);
        chk("stop_cap0", 32'(bus.cap_out), 0);
        #1 chk("sb_stop", 32'(exp_q.size()), 0);

        // runs at the period loaded alongside the stop; reset in tooth 30
        push_teeth(0, 29, 12);
        bus.ena = 1'b1;
        wait_stb(0, 30, "rst_t30");
        chk("pre_rst_cap", 32'(bus.cap_out), 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_cap", 32'(bus.cap_out), 0);
        chk("mid_rst_tooth", 32'(bus.tooth_num), 0);
        chk("mid_rst_tstb", 32'(bus.tooth_stb), 0);
        chk("mid_rst_gstb", 32'(bus.gap_stb), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        bus.ena = 1'b0;
        @(negedge clk);
        #1 chk("sb_rst", 32'(exp_q.size()), 0);
        rst = 1'b1;

        // restart after reset: start latency and first tooth
        push_teeth(0, 1, 8);
        load(8);
        bus.ena = 1'b1;
        @(negedge clk);
        chk("pre_start_busy", 32'(bus.busy), 0);
        @(negedge clk);
        chk("start_gstb", 32'(bus.gap_stb), 1);
        chk("start_tstb", 32'(bus.tooth_stb), 1);
        chk("start_cap", 32'(bus.cap_out), 1);
        chk("start_busy", 32'(bus.busy), 1);
        chk("start_tooth", 32'(bus.tooth_num), 0);
        wait_stb(0, 1, "restart_t1");
        stop_now();
        wait_idle("idle_restart");
        #1 chk("sb_restart", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/crank_wheel_gen.md
# crank_wheel_gen

Crankshaft trigger-wheel generator: a synthesisable 60-2 tooth-wheel waveform source that produces the filtered sensor signal consumed by the hardware angle generator. It runs from a programmable tooth period, applies period changes at tooth boundaries, and emits tooth and gap strobes for the bench and for closed-loop self-test. It sits next to the angle generator in the top level, with `cap_out` feedable into the capture input.

## Interface
Parameters:
- `PERIOD_WIDTH`, 24: width of the tooth-period counter and register.
- `TOOTH_WIDTH`, 8: width of the tooth index.
- `TEETH_TOTAL`, 60: tooth positions per revolution, including missing ones.
- `TEETH_MISSING`, 2: missing teeth at the end of the revolution.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `ena`  in  1  run request, level-sensitive.
- `period`  in  PERIOD_WIDTH  tooth period in `clk` cycles.
- `period_load`  in  1  single-cycle strobe that captures `period` into the shadow register.
- `cap_out`  out  1  generated wheel signal, registered.
- `tooth_num`  out  TOOTH_WIDTH  index of the current tooth position, 0..TEETH_TOTAL-1.
- `tooth_stb`  out  1  one-cycle pulse in the first cycle of every tooth position, including missing ones.
- `gap_stb`  out  1  one-cycle pulse in the first cycle of tooth 0, the first real tooth after the gap.
- `busy`  out  1  high while in RUN.

## Operation
- **Registers:** shadow period `sh_per` and active period `act_per`, both 0 on reset.
  - On `period_load`, `sh_per` takes `period`, clamped to a minimum of 4 if the value is 1..3.
  - `period` = 0 is stored as 0.
- **States:**
  - IDLE:
    - `cap_out`=0, `tooth_num`=0, phase counter `pcnt`=0.
    - Go to RUN when `ena`=1 and `sh_per`≠0.
    - On entry to RUN: `act_per`←`sh_per`, tooth 0 starts.
  - RUN:
    - `pcnt` counts 0..`act_per`-1.
    - At `pcnt`=`act_per`-1 (the tooth boundary):
      - `pcnt`←0.
      - `tooth_num` increments and wraps TEETH_TOTAL-1→0.
      - `act_per`←`sh_per`.
    - If `ena`=0 at a boundary, or `sh_per`=0 at a boundary, go to IDLE instead. A tooth is never truncated.
- **Waveform per tooth position:**
  - `cap_out`=1 while `pcnt` < `act_per`>>1, else 0.
  - Missing positions (`tooth_num` ≥ TEETH_TOTAL-TEETH_MISSING) hold `cap_out`=0 for the whole period.
  - The gap low time is therefore 2·P + (P - P/2) cycles.
- **Simultaneous events:**
  - `period_load` on the boundary cycle is not seen by that boundary; the old `sh_per` is used and the new value applies at the next boundary.
  - `ena` falling and `period_load` together: the load is captured, and the block stops at the boundary.
- **Reset mid-run:** all outputs and registers go to 0 immediately and the block is in IDLE. There is no partial tooth after reset release.

## Timing
- Reset values: every output is 0; internal state is IDLE.
- Start latency: if `ena` is sampled 1 in IDLE at edge n, the first cycle of tooth 0 is the cycle after edge n. In that cycle `cap_out`=1, `tooth_stb`=1, `gap_stb`=1, `busy`=1, `tooth_num`=0.
- All outputs are registered and change together; none has a combinational path from inputs.
- Revolution length is TEETH_TOTAL·P cycles. `gap_stb` period is TEETH_TOTAL·P.
- `busy` falls in the cycle after the last cycle of the final tooth. `cap_out` is already 0 by then.

## Structure
- Shared package `crank_gen_pkg`:
  - state enum {IDLE, RUN};
  - constants `CRANK_TEETH_TOTAL`=60, `CRANK_TEETH_MISSING`=2, `CRANK_MIN_PERIOD`=4.
- One sub-module, `crank_tooth_timer`:
  - contains `pcnt` and `act_per`;
  - outputs the boundary pulse and the high-phase flag.
- The top module owns the FSM, the shadow register, the tooth index and the strobes.

## Test plan
- **Basic revolution:** P=8, `ena`=1.
  - Within each tooth, `cap_out` is 4 cycles high then 4 low.
  - Teeth 0..57 each produce a pulse; teeth 58 and 59 are low for 16 cycles.
  - `gap_stb` recurs every 480 cycles; `tooth_stb` occurs every 8 cycles.
- **Mid-tooth period change:** P=8, then load P=20 at `pcnt`=3 of tooth 5.
  - Tooth 5 stays 8 cycles long.
  - Tooth 6 is 20 cycles: 10 high, 10 low.
- **Clamp and zero:**
  - Load P=2: the bench measures a 4-cycle tooth with 2 high.
  - Load P=0 then `ena`=1 from IDLE: `busy` stays 0 and `cap_out` stays 0 for 100 cycles.
- **Graceful stop:** drop `ena` at `pcnt`=1 of tooth 10 with P=8.
  - Tooth 10 completes: 4 high, 4 low.
  - `busy` goes 0 on the next cycle; `tooth_num`=0.
- **Reset mid-run:** assert `rst`=0 during the high phase of tooth 30.
  - All outputs are 0 in the same cycle.
  - After release with `ena`=1, the first tooth is tooth 0, with `gap_stb`=1 one cycle after `ena` is sampled.
- **Loopback:** connect `cap_out` to the angle-generator capture input with P=1000.
  - The gap is found after the first revolution.
  - The tooth counter then tracks `tooth_num` with a constant offset.
